// File: rtl/aes_pkg.sv
// Shared definitions for the AES core arbiter: state encoding,
// default data widths and key size codes.
package aes_pkg;

  // Default plaintext/ciphertext and core result widths
  localparam int AES_MSG_W = 128;
  localparam int AES_RES_W = 136;

  // Key size codes as seen by the core (forwarded without checking)
  localparam logic [2:0] KEY_128 = 3'b000;
  localparam logic [2:0] KEY_192 = 3'b001;
  localparam logic [2:0] KEY_256 = 3'b010;

  // Arbiter controller states, 4-bit to match the other controllers
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    START = 4'd1,
    RUN   = 4'd2,
    RESP  = 4'd3
  } arb_state_t;

endpackage

// File: rtl/aes_rr_pick.sv
// Two-input round-robin selector: the pointer breaks ties when both
// requesters are valid, otherwise the single valid requester wins.
module aes_rr_pick (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic       winner,
  output logic       any
);

  // Winner index and any-valid flag, purely combinational
  always_comb begin
    any    = |valid;
    winner = (&valid) ? ptr : valid[1];
  end

endmodule

// File: rtl/aes_arbiter.sv
// Shares one AES core between two block requesters. Grants round-robin,
// latches the winner's mode/key size/block, pulses the core's start/hold
// input, waits for done (with a timeout) and returns the result to the
// granted requester over a valid/ready response.
module aes_arbiter
  import aes_pkg::*;
#(
  parameter int START_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int MSG_W          = AES_MSG_W,
  parameter int RES_W          = AES_RES_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0Valid,
  output logic             req0Ready,
  input  logic             req0EncOrDec,
  input  logic [0:2]       req0KeySize,
  input  logic [0:MSG_W-1] req0Data,
  input  logic             req1Valid,
  output logic             req1Ready,
  input  logic             req1EncOrDec,
  input  logic [0:2]       req1KeySize,
  input  logic [0:MSG_W-1] req1Data,
  output logic             resp0Valid,
  input  logic             resp0Ready,
  output logic             resp1Valid,
  input  logic             resp1Ready,
  output logic [0:RES_W-1] respData,
  output logic             respTimeout,
  output logic             aesReset,
  output logic             aesEncOrDec,
  output logic [0:2]       aesKeySize,
  output logic [0:MSG_W-1] aesMessageIn,
  input  logic             aesDone,
  input  logic [0:RES_W-1] aesMessageOut
);

  localparam logic [3:0]  START_LAST = 4'(START_CYCLES - 1);
  localparam logic [15:0] RUN_LAST   = 16'(TIMEOUT_CYCLES - 1);

  arb_state_t  state;
  logic        grant;
  logic        ptr;
  logic [3:0]  start_cnt;
  logic [15:0] run_cnt;

  logic        pick_winner;
  logic        pick_any;
  logic        grant_now;
  logic        resp_done;
  logic        done_seen;
  logic        run_expired;

  aes_rr_pick u_pick (
    .valid  ({req1Valid, req0Valid}),
    .ptr    (ptr),
    .winner (pick_winner),
    .any    (pick_any)
  );

  // Ready is offered only in IDLE to the winner; the winner is always a
  // valid requester, so offering ready is the handshake. Held low in reset.
  always_comb begin
    grant_now   = reset && (state == IDLE) && pick_any;
    req0Ready   = grant_now && !pick_winner;
    req1Ready   = grant_now && pick_winner;
    resp_done   = (resp0Valid && resp0Ready) || (resp1Valid && resp1Ready);
    // The first RUN cycle may still see a done left over from the last block
    done_seen   = aesDone && (run_cnt != 16'd0);
    run_expired = (run_cnt == RUN_LAST);
  end

  // Controller FSM with counters, request latches and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      grant        <= 1'b0;
      ptr          <= 1'b0;
      start_cnt    <= '0;
      run_cnt      <= '0;
      aesReset     <= 1'b1;
      aesEncOrDec  <= 1'b0;
      aesKeySize   <= '0;
      aesMessageIn <= '0;
      resp0Valid   <= 1'b0;
      resp1Valid   <= 1'b0;
      respData     <= '0;
      respTimeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_now) begin
            grant        <= pick_winner;
            aesEncOrDec  <= pick_winner ? req1EncOrDec : req0EncOrDec;
            aesKeySize   <= pick_winner ? req1KeySize  : req0KeySize;
            aesMessageIn <= pick_winner ? req1Data     : req0Data;
            start_cnt    <= '0;
            state        <= START;
          end
        end
        START: begin
          if (start_cnt == START_LAST) begin
            aesReset <= 1'b0;
            run_cnt  <= '0;
            state    <= RUN;
          end else begin
            start_cnt <= start_cnt + 4'd1;
          end
        end
        RUN: begin
          if (done_seen || run_expired) begin
            // Done takes precedence over a coincident timeout
            respData    <= done_seen ? aesMessageOut : '0;
            respTimeout <= !done_seen;
            aesReset    <= 1'b1;
            resp0Valid  <= !grant;
            resp1Valid  <= grant;
            state       <= RESP;
          end else begin
            run_cnt <= run_cnt + 16'd1;
          end
        end
        RESP: begin
          if (resp_done) begin
            resp0Valid <= 1'b0;
            resp1Valid <= 1'b0;
            ptr        <= !grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_arbiter.sv
// Directed bench for aes_arbiter: contention, single request, timeout,
// response backpressure, reset mid-run and a stale done from the core.
module tb_aes_arbiter;

  localparam int TO_CYC = 16;
  localparam int DLY    = 10;
  localparam logic [135:0] STALE_OUT = {8'hEE, {16{8'hDE}}};

  logic           clock = 1'b0;
  logic           reset;
  logic           req0Valid, req1Valid;
  logic           req0Ready, req1Ready;
  logic           req0EncOrDec, req1EncOrDec;
  logic [0:2]     req0KeySize, req1KeySize;
  logic [0:127]   req0Data, req1Data;
  logic           resp0Valid, resp1Valid;
  logic           resp0Ready, resp1Ready;
  logic [0:135]   respData;
  logic           respTimeout;
  logic           aesReset;
  logic           aesEncOrDec;
  logic [0:2]     aesKeySize;
  logic [0:127]   aesMessageIn;
  logic           aesDone = 1'b0;
  logic [0:135]   aesMessageOut = '0;

  int compared   = 0;
  int mismatched = 0;
  int done_delay = DLY;
  bit done_en    = 1'b1;
  bit stale      = 1'b0;
  int core_k     = 0;

  always #5 clock = ~clock;

  aes_arbiter #(.START_CYCLES(2), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clock(clock), .reset(reset),
    .req0Valid(req0Valid), .req0Ready(req0Ready), .req0EncOrDec(req0EncOrDec),
    .req0KeySize(req0KeySize), .req0Data(req0Data),
    .req1Valid(req1Valid), .req1Ready(req1Ready), .req1EncOrDec(req1EncOrDec),
    .req1KeySize(req1KeySize), .req1Data(req1Data),
    .resp0Valid(resp0Valid), .resp0Ready(resp0Ready),
    .resp1Valid(resp1Valid), .resp1Ready(resp1Ready),
    .respData(respData), .respTimeout(respTimeout),
    .aesReset(aesReset), .aesEncOrDec(aesEncOrDec), .aesKeySize(aesKeySize),
    .aesMessageIn(aesMessageIn), .aesDone(aesDone), .aesMessageOut(aesMessageOut)
  );

  // Stand-in transform for the core result
  function automatic logic [135:0] core_fn(input logic enc, input logic [2:0] ks,
                                           input logic [127:0] d);
    return {enc, 2'b10, ks, 2'b01, d ^ (enc ? {16{8'h3C}} : {16{8'hC3}})};
  endfunction

  // Core model: done rises done_delay cycles after release and sticks until
  // aesReset; in stale mode it presents done with junk data while held
  always @(posedge clock) begin
    if (aesReset) begin
      core_k        = 0;
      aesDone       <= stale;
      aesMessageOut <= stale ? STALE_OUT : '0;
    end else begin
      core_k = core_k + 1;
      if (done_en && core_k >= done_delay) begin
        aesDone       <= 1'b1;
        aesMessageOut <= core_fn(aesEncOrDec, aesKeySize, aesMessageIn);
      end else begin
        aesDone <= 1'b0;
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request, wait (bounded) for ready, complete the handshake
  task automatic send(input int port, input logic enc, input logic [2:0] ks,
                      input logic [127:0] d);
    int n;
    if (port == 0) begin
      req0EncOrDec = enc; req0KeySize = ks; req0Data = d; req0Valid = 1'b1;
    end else begin
      req1EncOrDec = enc; req1KeySize = ks; req1Data = d; req1Valid = 1'b1;
    end
    #1;
    n = 0;
    while (!(port == 0 ? req0Ready : req1Ready) && n < 100) begin
      tick();
      n++;
    end
    chk($sformatf("send%0d_ready", port), 136'(port == 0 ? req0Ready : req1Ready), 136'd1);
    tick();
    chk($sformatf("send%0d_ready_drop", port), 136'(port == 0 ? req0Ready : req1Ready), 136'd0);
    if (port == 0) req0Valid = 1'b0; else req1Valid = 1'b0;
    chk("latch_msg", 136'(aesMessageIn), 136'(d));
    chk("latch_ks",  136'(aesKeySize), 136'(ks));
    chk("latch_enc", 136'(aesEncOrDec), 136'(enc));
  endtask

  // From the first START cycle: check the start pulse, then count RUN cycles
  task automatic expect_run(input int port, output int n);
    chk("start_c1", 136'(aesReset), 136'd1);
    tick();
    chk("start_c2", 136'(aesReset), 136'd1);
    tick();
    chk("run_c1", 136'(aesReset), 136'd0);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (port == 0 ? resp0Valid : resp1Valid) begin
        n = i;
        break;
      end
    end
  endtask

  // Check the pending response, then take it
  task automatic finish_resp(input int port, input logic [135:0] exp, input logic to);
    chk($sformatf("resp%0d_valid", port), 136'(port == 0 ? resp0Valid : resp1Valid), 136'd1);
    chk("resp_other_valid", 136'(port == 0 ? resp1Valid : resp0Valid), 136'd0);
    chk("resp_data", respData, exp);
    chk("resp_timeout", 136'(respTimeout), 136'(to));
    chk("resp_aesReset", 136'(aesReset), 136'd1);
    if (port == 0) resp0Ready = 1'b1; else resp1Ready = 1'b1;
    tick();
    resp0Ready = 1'b0;
    resp1Ready = 1'b0;
    chk($sformatf("resp%0d_clear", port), 136'(port == 0 ? resp0Valid : resp1Valid), 136'd0);
  endtask

  int n;
  bit bad;
  logic [127:0] da, db;

  initial begin
    reset = 1'b0;
    req0Valid = 1'b1; req1Valid = 1'b0;
    req0EncOrDec = 1'b0; req1EncOrDec = 1'b0;
    req0KeySize = '0; req1KeySize = '0;
    req0Data = '0; req1Data = '0;
    resp0Ready = 1'b0; resp1Ready = 1'b0;
    repeat (3) tick();
    chk("rst_aesReset", 136'(aesReset), 136'd1);
    chk("rst_req0Ready", 136'(req0Ready), 136'd0);
    chk("rst_resp_valid", 136'({resp0Valid, resp1Valid}), 136'd0);
    chk("rst_respData", respData, 136'd0);
    chk("rst_respTimeout", 136'(respTimeout), 136'd0);
    chk("rst_aes_regs", 136'({aesEncOrDec, aesKeySize, aesMessageIn}), 136'd0);
    req0Valid = 1'b0;
    reset = 1'b1;
    tick();

    // Contention from reset: port 0 first, port 1 afterwards
    da = 128'h0123456789abcdef0f1e2d3c4b5a6978;
    db = 128'hfedcba98765432100011223344556677;
    req0EncOrDec = 1'b1; req0KeySize = 3'b001; req0Data = da; req0Valid = 1'b1;
    req1EncOrDec = 1'b0; req1KeySize = 3'b010; req1Data = db; req1Valid = 1'b1;
    #1;
    chk("cont_ready0", 136'(req0Ready), 136'd1);
    chk("cont_ready1", 136'(req1Ready), 136'd0);
    send(0, 1'b1, 3'b001, da);
    chk("cont_hold1", 136'(req1Ready), 136'd0);
    expect_run(0, n);
    chk("cont_lat0", 136'(n), 136'(DLY + 1));
    chk("cont_hold1_resp", 136'(req1Ready), 136'd0);
    finish_resp(0, core_fn(1'b1, 3'b001, da), 1'b0);
    chk("cont_ready1_next", 136'(req1Ready), 136'd1);
    send(1, 1'b0, 3'b010, db);
    expect_run(1, n);
    chk("cont_lat1", 136'(n), 136'(DLY + 1));
    finish_resp(1, core_fn(1'b0, 3'b010, db), 1'b0);

    // Single request with the reference vector
    da = 128'h00112233445566778899aabbccddeeff;
    send(0, 1'b1, 3'b001, da);
    expect_run(0, n);
    chk("single_lat", 136'(n), 136'(DLY + 1));
    finish_resp(0, core_fn(1'b1, 3'b001, da), 1'b0);

    // Simultaneous pair after serving port 0: port 1 goes first
    db = 128'h55555555aaaaaaaa5555aaaa55aa55aa;
    req0EncOrDec = 1'b0; req0KeySize = 3'b000; req0Data = da; req0Valid = 1'b1;
    req1EncOrDec = 1'b1; req1KeySize = 3'b010; req1Data = db; req1Valid = 1'b1;
    #1;
    chk("pair_ready1", 136'(req1Ready), 136'd1);
    chk("pair_ready0", 136'(req0Ready), 136'd0);
    send(1, 1'b1, 3'b010, db);
    expect_run(1, n);
    finish_resp(1, core_fn(1'b1, 3'b010, db), 1'b0);
    chk("pair_ready0_next", 136'(req0Ready), 136'd1);
    send(0, 1'b0, 3'b000, da);
    expect_run(0, n);
    finish_resp(0, core_fn(1'b0, 3'b000, da), 1'b0);

    // Timeout: the core never finishes
    done_en = 1'b0;
    send(0, 1'b1, 3'b010, 128'hcafef00d);
    expect_run(0, n);
    chk("to_lat", 136'(n), 136'(TO_CYC));
    finish_resp(0, 136'd0, 1'b1);
    done_en = 1'b1;
    send(1, 1'b0, 3'b001, 128'h1234);
    expect_run(1, n);
    chk("after_to_lat", 136'(n), 136'(DLY + 1));
    finish_resp(1, core_fn(1'b0, 3'b001, 128'h1234), 1'b0);

    // Backpressure on port 1 while port 0 waits
    db = 128'hdeadbeef00000000ffffffff12345678;
    send(1, 1'b1, 3'b000, db);
    expect_run(1, n);
    req0EncOrDec = 1'b0; req0KeySize = 3'b001; req0Data = 128'h77; req0Valid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (resp1Valid !== 1'b1 || respData !== core_fn(1'b1, 3'b000, db) || req0Ready !== 1'b0)
        bad = 1'b1;
    end
    chk("bp_stable", 136'(bad), 136'd0);
    finish_resp(1, core_fn(1'b1, 3'b000, db), 1'b0);
    chk("bp_ready0_next", 136'(req0Ready), 136'd1);
    send(0, 1'b0, 3'b001, 128'h77);
    expect_run(0, n);
    finish_resp(0, core_fn(1'b0, 3'b001, 128'h77), 1'b0);

    // Reset dropped five cycles into RUN
    send(0, 1'b1, 3'b001, 128'h9999);
    tick();
    tick();
    chk("mr_in_run", 136'(aesReset), 136'd0);
    repeat (5) tick();
    req1Data = 128'h4444; req1Valid = 1'b1;
    reset = 1'b0;
    #1;
    chk("mr_aesReset", 136'(aesReset), 136'd1);
    chk("mr_ready", 136'({req0Ready, req1Ready}), 136'd0);
    chk("mr_valid", 136'({resp0Valid, resp1Valid}), 136'd0);
    tick();
    tick();
    req1Valid = 1'b0;
    reset = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (resp0Valid !== 1'b0 || resp1Valid !== 1'b0) bad = 1'b1;
    end
    chk("mr_no_resp", 136'(bad), 136'd0);
    da = 128'hf0f0f0f00f0f0f0f1111222233334444;
    send(0, 1'b1, 3'b010, da);
    expect_run(0, n);
    chk("mr_fresh_lat", 136'(n), 136'(DLY + 1));
    finish_resp(0, core_fn(1'b1, 3'b010, da), 1'b0);

    // Stale done held through START and the first RUN cycle
    stale = 1'b1;
    db = 128'h0badc0de0badc0de0badc0de0badc0d;
    send(1, 1'b0, 3'b000, db);
    expect_run(1, n);
    stale = 1'b0;
    chk("stale_lat", 136'(n), 136'(DLY + 1));
    finish_resp(1, core_fn(1'b0, 3'b000, db), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
